// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop.
// Operands shift LSB-first; results publish together with a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] sum_sr;
  logic [CW-1:0]    cnt;
  logic             carry;

  logic             load;
  logic             shift;
  logic             last;
  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] sum_nx;

  // Single full-adder cell on the current LSBs.
  always_comb begin
    s_bit  = a_sr[0] ^ b_sr[0] ^ carry;
    c_bit  = (a_sr[0] & b_sr[0])
           | (a_sr[0] & carry)
           | (b_sr[0] & carry);
    sum_nx = {s_bit, sum_sr};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and datapath controls.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    shift    = 1'b0;
    last     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        shift = 1'b1;
        if (cnt == LAST) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand load, serial shift and result publication.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      S      <= '0;
      Cout   <= 1'b0;
      V      <= 1'b0;
    end else if (load) begin
      a_sr   <= A;
      b_sr   <= sub ? ~B : B;
      sum_sr <= '0;
      carry  <= sub;
      cnt    <= '0;
    end else if (shift) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= sum_nx[WIDTH-1:1];
      carry  <= c_bit;
      cnt    <= cnt + 1'b1;
      if (last) begin
        // carry here is the carry into the MSB
        S    <= sum_nx;
        Cout <= c_bit;
        V    <= c_bit ^ carry;
      end
    end
  end

  // Status flags decode directly from state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8-bit directed/random ops,
// 4-bit exhaustive back-to-back, mid-run start and reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, sub8, busy8, done8, cout8, v8;
  logic [7:0] a8, b8, s8;

  logic       start4, sub4, busy4, done4, cout4, v4;
  logic [3:0] a4, b4, s4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .start(start8),
    .sub  (sub8),
    .A    (a8),
    .B    (b8),
    .busy (busy8),
    .done (done8),
    .S    (s8),
    .Cout (cout8),
    .V    (v8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk  (clk),
    .rst  (rst),
    .start(start4),
    .sub  (sub4),
    .A    (a4),
    .B    (b4),
    .busy (busy4),
    .done (done4),
    .S    (s4),
    .Cout (cout4),
    .V    (v4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views.
  task automatic model(input int w,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic s,
                       output logic [31:0] rs,
                       output logic rc,
                       output logic rv);
    longint m, ua, ub, t, sa, sb, r;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    t  = s ? (ua + (m - 1 - ub) + 1) : (ua + ub);
    rs = 32'(t % m);
    rc = (t >= m);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    r  = s ? sa - sb : sa + sb;
    rv = (r < -(m / 2)) || (r >= m / 2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic s,
                      input string tag);
    logic [31:0] es;
    logic ec, ev;
    int bc, n;
    bit seen;
    model(8, {24'd0, a}, {24'd0, b}, s, es, ec, ev);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    bc = 0; n = 0; seen = 0;
    while (!seen && n < 20) begin
      if (done8) seen = 1;
      else begin
        if (busy8) bc++;
        tick();
        n++;
      end
    end
    chk({tag, ".done"}, 32'(seen), 1);
    chk({tag, ".lat"}, n, 8);
    chk({tag, ".busycyc"}, bc, 8);
    chk({tag, ".busy@done"}, 32'(busy8), 0);
    chk({tag, ".S"}, 32'(s8), es);
    chk({tag, ".Cout"}, 32'(cout8), 32'(ec));
    chk({tag, ".V"}, 32'(v8), 32'(ev));
    tick();
    chk({tag, ".pulse"}, 32'(done8), 0);
    chk({tag, ".hold"}, 32'(s8), es);
  endtask

  logic [31:0] es, ps;
  logic        ec, ev, pc, pv;
  logic [8:0]  op;

  initial begin
    rst = 1'b1;
    start8 = 0; sub8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sub4 = 0; a4 = 0; b4 = 0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst.busy", 32'(busy8), 0);
    chk("rst.done", 32'(done8), 0);
    chk("rst.S", 32'(s8), 0);
    chk("rst.Cout", 32'(cout8), 0);
    chk("rst.V", 32'(v8), 0);
    chk("rst.S4", 32'(s4), 0);

    run8(8'h3C, 8'h45, 1'b0, "add3c45");
    run8(8'hFF, 8'h01, 1'b0, "addff01");
    run8(8'h05, 8'h07, 1'b1, "sub0507");
    run8(8'h80, 8'h01, 1'b1, "sub8001");
    run8(8'h10, 8'h10, 1'b1, "sub1010");
    for (int i = 0; i < 40; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), "rand");

    // start and operand changes during RUN are ignored
    a8 = 8'h3C; b8 = 8'h45; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 3) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b1;
      end else begin
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      end
      chk("mid.busy", 32'(busy8), 1);
      tick();
    end
    chk("mid.done", 32'(done8), 1);
    chk("mid.S", 32'(s8), 32'h81);
    chk("mid.Cout", 32'(cout8), 0);
    chk("mid.V", 32'(v8), 1);
    tick();

    // reset together with start in mid-RUN abandons the op
    a8 = 8'h3C; b8 = 8'h46; sub8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1; start8 = 1'b1;
    tick();
    rst = 1'b0; start8 = 1'b0;
    chk("rrun.busy", 32'(busy8), 0);
    chk("rrun.done", 32'(done8), 0);
    chk("rrun.S", 32'(s8), 0);
    chk("rrun.Cout", 32'(cout8), 0);
    chk("rrun.V", 32'(v8), 0);
    for (int i = 0; i < 10; i++) begin
      chk("rrun.nodone", 32'(done8 | busy8), 0);
      tick();
    end
    run8(8'h7F, 8'h01, 1'b0, "postrst");

    // 4-bit exhaustive, start held high back-to-back
    ps = 0; pc = 0; pv = 0;
    op = 9'd0;
    a4 = op[7:4]; b4 = op[3:0]; sub4 = op[8];
    start4 = 1'b1;
    for (int k = 0; k < 512; k++) begin
      model(4, {28'd0, a4}, {28'd0, b4}, sub4, es, ec, ev);
      tick();
      if (k < 511) begin
        op = 9'(k + 1);
        a4 = op[7:4]; b4 = op[3:0]; sub4 = op[8];
      end else begin
        start4 = 1'b0;
      end
      for (int j = 0; j < 4; j++) begin
        chk("ex.busy", 32'(busy4), 1);
        chk("ex.done0", 32'(done4), 0);
        chk("ex.Shold", 32'(s4), ps);
        if (j < 3) tick();
      end
      tick();
      chk("ex.done", 32'(done4), 1);
      chk("ex.busy0", 32'(busy4), 0);
      chk("ex.S", 32'(s4), es);
      chk("ex.Cout", 32'(cout4), 32'(ec));
      chk("ex.V", 32'(v4), 32'(ev));
      ps = es; pc = ec; pv = ev;
    end
    tick();
    chk("ex.idle", 32'(done4 | busy4), 0);
    chk("ex.last", {29'd0, pv, pc, 1'b0}, {29'd0, v4, cout4, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
